// File: rtl/fir_stream_driver.sv
// fir_stream_driver: collects FIR coefficients, programs them into the FIR
// through its x_in pin, then streams buffered samples. Option: FIR_DRV_HOLD_EN.
module fir_stream_driver #(
   parameter int N_TAPS     = 4,
   parameter int BW_IN      = 6,
   parameter int BW_OUT     = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [BW_IN-1:0]  coef_in,
   input  logic              coef_valid,
   output logic              coef_ready,
   input  logic [BW_IN-1:0]  smp_in,
   input  logic              smp_valid,
   output logic              smp_ready,
   input  logic              reload,
   output logic              fir_rst,
   output logic [BW_IN-1:0]  fir_x,
   input  logic [BW_OUT-1:0] fir_y,
   output logic [BW_OUT-1:0] y_out,
   output logic              y_valid,
   output logic              underrun
);

   localparam int IW = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int FW = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {
      S_COLLECT = 2'd0,
      S_PROGRAM = 2'd1,
      S_STREAM  = 2'd2
   } state_t;

   state_t state_q, state_d;

   // coefficient store and shared collect/program counter
   logic [BW_IN-1:0] coef_q [N_TAPS];
   logic [IW-1:0]    cnt_q, cnt_d;

   // sample FIFO
   logic [BW_IN-1:0] mem_q [FIFO_DEPTH];
   logic [PW-1:0]    wr_q, wr_d;
   logic [PW-1:0]    rd_q, rd_d;
   logic [FW-1:0]    fcnt_q, fcnt_d;
   logic [BW_IN-1:0] rd_data;

   // registered FIR drive and result path
   logic              fir_rst_q, fir_rst_d;
   logic [BW_IN-1:0]  fir_x_q, fir_x_d;
   logic [2:0]        tag_q, tag_d;
   logic              tag_in;
   logic [BW_OUT-1:0] y_out_q, y_out_d;
   logic              y_valid_q, y_valid_d;
   logic              und_q, und_d;

   // handshake strobes
   logic coef_hs;
   logic push;
   logic pop;
   logic last_coef;
   logic [BW_IN-1:0] bubble;

   assign rd_data   = mem_q[rd_q];
   assign last_coef = (cnt_q == IW'(N_TAPS - 1));

`ifdef FIR_DRV_HOLD_EN
   logic [BW_IN-1:0] last_q, last_d;

   // remember the most recent popped sample; reload forgets it
   always_comb begin
      last_d = last_q;
      if (reload)
         last_d = '0;
      else if (pop)
         last_d = rd_data;
   end

   // hold register for bubble re-drive
   always_ff @(posedge clk) begin
      if (reset)
         last_q <= '0;
      else
         last_q <= last_d;
   end

   assign bubble = last_q;
`else
   assign bubble = '0;
`endif

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset)
         state_q <= S_COLLECT;
      else
         state_q <= state_d;
   end

   // FSM next-state: reload always wins back to COLLECT
   always_comb begin
      state_d = state_q;
      if (reload) begin
         state_d = S_COLLECT;
      end else begin
         unique case (state_q)
            S_COLLECT: if (coef_hs && last_coef) state_d = S_PROGRAM;
            S_PROGRAM: if (cnt_q == '0)          state_d = S_STREAM;
            S_STREAM:  state_d = S_STREAM;
            default:   state_d = S_COLLECT;
         endcase
      end
   end

   // FSM outputs: handshake readiness and FIFO strobes
   always_comb begin
      coef_ready = (state_q == S_COLLECT);
      smp_ready  = (fcnt_q != FW'(FIFO_DEPTH));
      coef_hs    = coef_valid && coef_ready;
      push       = smp_valid && smp_ready;
      // a word pushed this cycle into an empty FIFO is not visible yet
      pop        = (state_q == S_STREAM) && (fcnt_q != '0) && !reload;
   end

   // FIFO pointer and occupancy next-state
   always_comb begin
      wr_d   = wr_q;
      rd_d   = rd_q;
      fcnt_d = fcnt_q;
      if (push)
         wr_d = (wr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_q + PW'(1);
      if (pop)
         rd_d = (rd_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_q + PW'(1);
      unique case ({push, pop})
         2'b10:   fcnt_d = fcnt_q + FW'(1);
         2'b01:   fcnt_d = fcnt_q - FW'(1);
         default: fcnt_d = fcnt_q;
      endcase
   end

   // FIFO pointers and count
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_q   <= '0;
         rd_q   <= '0;
         fcnt_q <= '0;
      end else begin
         wr_q   <= wr_d;
         rd_q   <= rd_d;
         fcnt_q <= fcnt_d;
      end
   end

   // FIFO storage needs no reset; occupancy gates every read
   always_ff @(posedge clk) begin
      if (push)
         mem_q[wr_q] <= smp_in;
   end

   // coefficient capture during COLLECT
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N_TAPS; i++)
            coef_q[i] <= '0;
      end else if (coef_hs && !reload) begin
         coef_q[cnt_q] <= coef_in;
      end
   end

   // FIR drive next-state: reset pin, x_in mux, tag and underrun
   always_comb begin
      fir_rst_d = fir_rst_q;
      fir_x_d   = fir_x_q;
      cnt_d     = cnt_q;
      und_d     = und_q;
      tag_in    = 1'b0;
      if (reload) begin
         fir_rst_d = 1'b1;
         fir_x_d   = '0;
         cnt_d     = '0;
         und_d     = 1'b0;
      end else begin
         unique case (state_q)
            S_COLLECT: begin
               fir_rst_d = 1'b1;
               fir_x_d   = '0;
               // leaving COLLECT, the counter turns into a top-down index
               if (coef_hs)
                  cnt_d = last_coef ? IW'(N_TAPS - 1) : cnt_q + IW'(1);
            end
            S_PROGRAM: begin
               fir_rst_d = 1'b0;
               fir_x_d   = coef_q[cnt_q];
               if (cnt_q != '0)
                  cnt_d = cnt_q - IW'(1);
            end
            S_STREAM: begin
               fir_rst_d = 1'b0;
               if (pop) begin
                  fir_x_d = rd_data;
                  tag_in  = 1'b1;
               end else begin
                  fir_x_d = bubble;
                  und_d   = 1'b1;
               end
            end
            default: begin
               fir_rst_d = 1'b1;
               fir_x_d   = '0;
            end
         endcase
      end
   end

   // result capture: the tag leaving the pipe qualifies fir_y
   always_comb begin
      tag_d     = reload ? 3'b000 : {tag_q[1:0], tag_in};
      y_valid_d = tag_q[2] && !reload;
      y_out_d   = y_valid_d ? fir_y : y_out_q;
   end

   // drive, tag and result registers
   always_ff @(posedge clk) begin
      if (reset) begin
         fir_rst_q <= 1'b1;
         fir_x_q   <= '0;
         cnt_q     <= '0;
         und_q     <= 1'b0;
         tag_q     <= 3'b000;
         y_out_q   <= '0;
         y_valid_q <= 1'b0;
      end else begin
         fir_rst_q <= fir_rst_d;
         fir_x_q   <= fir_x_d;
         cnt_q     <= cnt_d;
         und_q     <= und_d;
         tag_q     <= tag_d;
         y_out_q   <= y_out_d;
         y_valid_q <= y_valid_d;
      end
   end

   assign fir_rst  = fir_rst_q;
   assign fir_x    = fir_x_q;
   assign y_out    = y_out_q;
   assign y_valid  = y_valid_q;
   assign underrun = und_q;

endmodule

// File: doc/fir_stream_driver.md
FIR_STREAM_DRIVER -- requirements
Module: fir_stream_driver

Interface
REQ-001 SHALL have parameter N_TAPS, default 4, the number of FIR taps driven.
REQ-002 SHALL have parameter BW_IN, default 6, the coefficient and sample width.
REQ-003 SHALL have parameter BW_OUT, default 8, the FIR result width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4 (power of 2), the sample buffer depth.
REQ-005 clk  in  1  clock; all logic on the rising edge.
REQ-006 reset  in  1  reset, synchronous, active-high.
REQ-007 coef_in/coef_valid/coef_ready  in/in/out  BW_IN/1/1  coefficient stream: h0 (newest-sample tap) first, h[N_TAPS-1] last.
REQ-008 smp_in/smp_valid/smp_ready  in/in/out  BW_IN/1/1  sample stream into the FIFO.
REQ-009 reload  in  1  single-cycle request to reprogram coefficients.
REQ-010 fir_rst/fir_x  out/out  1/BW_IN  registered drive to the FIR's reset and x_in pins.
REQ-011 fir_y  in  BW_OUT  FIR output y_out.
REQ-012 y_out/y_valid  out/out  BW_OUT/1  captured result for each real sample.
REQ-013 underrun  out  1  sticky flag: a bubble was inserted in STREAM.

Function
REQ-014 SHALL implement the FSM COLLECT -> PROGRAM -> STREAM; reset enters COLLECT.
REQ-015 COLLECT: fir_rst=1, fir_x=0, coef_ready=1; each coef_valid&coef_ready stores h[count], count++; after the N_TAPS-th handshake, go to PROGRAM.
REQ-016 PROGRAM: fir_rst=0 and fir_x=h[N_TAPS-1] on the same edge, then h[N_TAPS-2] ... h[0] on consecutive edges (reverse order), N_TAPS cycles total, no gaps; then STREAM.
REQ-017 STREAM: each cycle, if the FIFO is non-empty, pop one sample into fir_x; otherwise drive a bubble (REQ-028) and set underrun.
REQ-018 smp_ready SHALL be 1 when the FIFO is not full, in every state; samples are buffered during COLLECT/PROGRAM.
REQ-019 Full FIFO with simultaneous pop SHALL keep smp_ready=0 that cycle (no push on full); empty FIFO with simultaneous push SHALL NOT pop the new word that cycle.
REQ-020 The pointers SHALL wrap modulo FIFO_DEPTH; count SHALL range 0..FIFO_DEPTH.
REQ-021 Each fir_x update SHALL push a tag bit (1=real sample, 0=bubble/coef) into a 3-stage pipeline. When the tag exits, fir_y SHALL be registered into y_out and y_valid=tag.
REQ-022 Timing: a sample popped at edge E0 SHALL have its result at y_out with y_valid=1 after edge E3.
REQ-023 y_out SHALL hold its last value when y_valid=0.
REQ-024 reload in any state SHALL return to COLLECT next edge, assert fir_rst, clear count, tag pipeline, and underrun, and keep FIFO contents.
REQ-025 coef_valid outside COLLECT SHALL be ignored (coef_ready=0).
REQ-026 reset and reload in the same cycle SHALL behave as reset.

Reset
REQ-027 On reset: state=COLLECT, fir_rst=1, fir_x=0, y_out=0, y_valid=0, underrun=0, FIFO empty, coefficient count=0, stored coefficients=0, tag pipeline=0.

Configuration
REQ-028 Macro FIR_DRV_HOLD_EN: when defined, a bubble re-drives the last popped sample (or 0 if none since reset/reload). When undefined, a bubble drives 0. Bubbles SHALL be tagged 0 in both cases.

Verification
REQ-029 Reset, load coefs 1,2,3,4, push 1,0,0,0 -> fir_x during PROGRAM = 4,3,2,1; y_out = 1,2,3,4 with y_valid=1.
REQ-030 Coefs 1,1,1,1, samples 1,2,3,4,5 with no gaps -> y_out = 1,3,6,10,14 on consecutive cycles; underrun=0.
REQ-031 Push 5 samples with FIFO_DEPTH=4 during COLLECT, smp_valid held -> smp_ready=0 after 4 pushes; the 5th sample is accepted after the first STREAM pop.
REQ-032 FIFO empty in STREAM for 2 cycles -> 2 cycles y_valid=0, underrun=1, fir_x=0 (hold: last sample).
REQ-033 Reload mid-STREAM with samples queued -> fir_rst=1 next cycle, y_valid=0, underrun=0; new coefs 2,0,0,0 with sample 3 -> y_out=6.
REQ-034 Assert reset during PROGRAM -> all outputs match REQ-027 next cycle; the FIFO is empty.
